// File: rtl/pe_multimode.sv
// pe_multimode: systolic processing element with a runtime weight-stationary (WS) or
// output-stationary (OS) mode, a signed MAC, a double-buffered weight, registered
// east/south forwarding, an OS accumulator drain chain and a sticky overflow flag.
// Optional build macro: PE_SAT_EN. When it is defined, overflowing adds clamp to the
// signed ACC_W range. When it is undefined, overflowing adds wrap.
module pe_multimode #(
    parameter int IN_W  = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pe_enabled,
    input  logic             pe_mode,
    input  logic [ACC_W-1:0] pe_psum_in,
    input  logic             pe_psum_valid_in,
    input  logic [W_W-1:0]   pe_weight_in,
    input  logic             pe_accept_w_in,
    input  logic [IN_W-1:0]  pe_input_in,
    input  logic             pe_valid_in,
    input  logic             pe_switch_in,
    input  logic             pe_drain_in,
    output logic [ACC_W-1:0] pe_psum_out,
    output logic             pe_psum_valid_out,
    output logic [W_W-1:0]   pe_weight_out,
    output logic [IN_W-1:0]  pe_input_out,
    output logic             pe_valid_out,
    output logic             pe_switch_out,
    output logic             pe_ovf_out
);

    localparam int P_W = IN_W + W_W;

    typedef enum logic {
        MODE_WS = 1'b0,
        MODE_OS = 1'b1
    } mode_e;

    // Signed add with overflow detection: bit ACC_W is the overflow flag, the low bits are the sum.
    function automatic logic [ACC_W:0] add_chk(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W-1:0] s;
        logic                    ovf;
        s   = a + b;
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
`ifdef PE_SAT_EN
        if (ovf) begin
            s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
        return {ovf, s};
    endfunction

    mode_e                   mode_q, mode_d;
    logic signed [W_W-1:0]   w_act_q, w_act_d;
    logic signed [W_W-1:0]   w_inact_q, w_inact_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0]        psum_out_q, psum_out_d;
    logic                    psum_valid_q, psum_valid_d;
    logic [W_W-1:0]          weight_out_q, weight_out_d;
    logic [IN_W-1:0]         input_out_q, input_out_d;
    logic                    valid_out_q, valid_out_d;
    logic                    switch_out_q, switch_out_d;
    logic                    ovf_q, ovf_d;

    logic signed [W_W-1:0]   operand_s;
    logic signed [P_W-1:0]   prod_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic [ACC_W:0]          ws_add_s;
    logic [ACC_W:0]          os_add_s;

    // Datapath: operand select (the WS switch bypasses the inactive weight in the same cycle), product and both adds.
    always_comb begin
        operand_s = $signed(pe_weight_in);
        if (mode_q == MODE_WS) begin
            operand_s = pe_switch_in ? w_inact_q : w_act_q;
        end else begin
            operand_s = $signed(pe_weight_in);
        end
        prod_s     = P_W'($signed(pe_input_in)) * P_W'(operand_s);
        prod_ext_s = ACC_W'(prod_s);
        ws_add_s   = add_chk($signed(pe_psum_in), prod_ext_s);
        os_add_s   = add_chk(acc_q, prod_ext_s);
    end

    // Next-state logic: the enable clear has priority, then the mode-change bubble, then normal WS/OS operation.
    always_comb begin
        mode_d       = mode_q;
        w_act_d      = w_act_q;
        w_inact_d    = w_inact_q;
        acc_d        = acc_q;
        psum_out_d   = psum_out_q;
        psum_valid_d = 1'b0;
        weight_out_d = weight_out_q;
        input_out_d  = input_out_q;
        valid_out_d  = 1'b0;
        switch_out_d = 1'b0;
        ovf_d        = ovf_q;

        if (!pe_enabled) begin
            mode_d       = MODE_WS;
            w_act_d      = '0;
            w_inact_d    = '0;
            acc_d        = '0;
            psum_out_d   = '0;
            weight_out_d = '0;
            input_out_d  = '0;
            ovf_d        = 1'b0;
        end else if (mode_e'(pe_mode) != mode_q) begin
            // One bubble: flush mode-specific state and ignore this cycle's stimulus.
            mode_d       = mode_e'(pe_mode);
            w_act_d      = '0;
            w_inact_d    = '0;
            acc_d        = '0;
            psum_out_d   = '0;
            weight_out_d = '0;
        end else begin
            valid_out_d  = pe_valid_in;
            switch_out_d = pe_switch_in;
            if (pe_valid_in) begin
                input_out_d = pe_input_in;
            end else begin
                input_out_d = input_out_q;
            end

            if (mode_q == MODE_WS) begin
                weight_out_d = pe_accept_w_in ? pe_weight_in : '0;
                if (pe_switch_in) begin
                    w_act_d = w_inact_q;
                end else begin
                    w_act_d = w_act_q;
                end
                if (pe_accept_w_in) begin
                    w_inact_d = $signed(pe_weight_in);
                end else begin
                    w_inact_d = w_inact_q;
                end
                if (pe_valid_in) begin
                    psum_out_d   = ws_add_s[ACC_W-1:0];
                    psum_valid_d = 1'b1;
                    ovf_d        = ovf_q | ws_add_s[ACC_W];
                end else begin
                    psum_out_d   = '0;
                    psum_valid_d = 1'b0;
                end
            end else begin
                weight_out_d = pe_valid_in ? pe_weight_in : '0;
                if (pe_drain_in) begin
                    // Drain starts a new tile; an upstream word arriving now is dropped.
                    psum_out_d   = acc_q;
                    psum_valid_d = 1'b1;
                    acc_d        = pe_valid_in ? prod_ext_s : '0;
                end else begin
                    if (pe_valid_in) begin
                        acc_d = os_add_s[ACC_W-1:0];
                        ovf_d = ovf_q | os_add_s[ACC_W];
                    end else begin
                        acc_d = acc_q;
                    end
                    if (pe_psum_valid_in) begin
                        psum_out_d   = pe_psum_in;
                        psum_valid_d = 1'b1;
                    end else begin
                        psum_out_d   = psum_out_q;
                        psum_valid_d = 1'b0;
                    end
                end
            end
        end
    end

    // State and output registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= MODE_WS;
            w_act_q      <= '0;
            w_inact_q    <= '0;
            acc_q        <= '0;
            psum_out_q   <= '0;
            psum_valid_q <= 1'b0;
            weight_out_q <= '0;
            input_out_q  <= '0;
            valid_out_q  <= 1'b0;
            switch_out_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            w_act_q      <= w_act_d;
            w_inact_q    <= w_inact_d;
            acc_q        <= acc_d;
            psum_out_q   <= psum_out_d;
            psum_valid_q <= psum_valid_d;
            weight_out_q <= weight_out_d;
            input_out_q  <= input_out_d;
            valid_out_q  <= valid_out_d;
            switch_out_q <= switch_out_d;
            ovf_q        <= ovf_d;
        end
    end

    assign pe_psum_out       = psum_out_q;
    assign pe_psum_valid_out = psum_valid_q;
    assign pe_weight_out     = weight_out_q;
    assign pe_input_out      = input_out_q;
    assign pe_valid_out      = valid_out_q;
    assign pe_switch_out     = switch_out_q;
    assign pe_ovf_out        = ovf_q;

endmodule
